// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing a 4-digit seven-segment display between three clients.
// Optional leading-zero blanking is enabled by defining SEG_ARB_LZB_EN.
module seg_display_arbiter #(
    parameter int unsigned MAX_HOLD   = 1000,
    parameter logic [3:0]  BLANK_CODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  gnt,
    output logic        busy,
    output logic [3:0]  BCD0,
    output logic [3:0]  BCD1,
    output logic [3:0]  BCD2,
    output logic [3:0]  BCD3
);

    localparam int unsigned   HW      = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD - 1);
    localparam logic [15:0]   Blank   = {4{BLANK_CODE}};

    typedef enum logic {StIdle, StGrant} state_e;

    state_e        state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    ptr_q, ptr_d;

    logic [1:0]    owner;
    logic [2:0]    pick;

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Returns {found, index} of the first set bit of r searching from start.
    function automatic logic [2:0] rr_pick(input logic [1:0] start, input logic [2:0] r);
        logic [1:0] i;
        logic [2:0] res;
        i   = start;
        res = 3'b000;
        for (int n = 0; n < 3; n++) begin
            if (!res[2] && r[i]) res = {1'b1, i};
            i = inc3(i);
        end
        return res;
    endfunction

    function automatic logic [15:0] fmt(input logic [15:0] w);
`ifdef SEG_ARB_LZB_EN
        logic b3, b2, b1;
        b3 = (w[15:12] == 4'd0) || (w[15:12] == BLANK_CODE);
        b2 = b3 && ((w[11:8] == 4'd0) || (w[11:8] == BLANK_CODE));
        b1 = b2 && (w[7:4] == 4'd0);
        return {(w[15:12] == 4'd0) ? BLANK_CODE : w[15:12],
                (b2 && w[11:8] == 4'd0) ? BLANK_CODE : w[11:8],
                b1 ? BLANK_CODE : w[7:4],
                w[3:0]};
`else
        return w;
`endif
    endfunction

    function automatic logic [15:0] sel(input logic [1:0] i, input logic [15:0] d0,
                                        input logic [15:0] d1, input logic [15:0] d2);
        case (i)
            2'd0:    return d0;
            2'd1:    return d1;
            default: return d2;
        endcase
    endfunction

    assign owner = gnt_q[2] ? 2'd2 : (gnt_q[1] ? 2'd1 : 2'd0);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        bcd_d   = bcd_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        pick    = 3'b000;
        case (state_q)
            StIdle: begin
                pick   = rr_pick(ptr_q, req);
                gnt_d  = 3'b000;
                busy_d = 1'b0;
                bcd_d  = Blank;
                if (pick[2]) begin
                    state_d = StGrant;
                    gnt_d   = 3'(3'b001 << pick[1:0]);
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    bcd_d   = fmt(sel(pick[1:0], data0, data1, data2));
                end
            end
            default: begin
                pick = rr_pick(inc3(owner), req & ~gnt_q);
                if (!req[owner]) begin
                    state_d = StIdle;
                    gnt_d   = 3'b000;
                    busy_d  = 1'b0;
                    bcd_d   = Blank;
                    hold_d  = '0;
                    ptr_d   = inc3(owner);
                end else if (hold_q == HoldMax && pick[2]) begin
                    // Direct handover: no blank cycle between owners.
                    gnt_d  = 3'(3'b001 << pick[1:0]);
                    bcd_d  = fmt(sel(pick[1:0], data0, data1, data2));
                    hold_d = '0;
                    ptr_d  = inc3(owner);
                end else begin
                    bcd_d  = fmt(sel(owner, data0, data1, data2));
                    hold_d = (hold_q == HoldMax) ? hold_q : hold_q + HW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 3'b000;
            busy_q  <= 1'b0;
            bcd_q   <= Blank;
            hold_q  <= '0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            bcd_q   <= bcd_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign BCD0 = bcd_q[3:0];
    assign BCD1 = bcd_q[7:4];
    assign BCD2 = bcd_q[11:8];
    assign BCD3 = bcd_q[15:12];

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Round-robin arbiter that shares the 4-digit seven-segment display between three requesting clients (e.g. counter, setup menu, status message). Each client presents a 4-digit BCD word and a request. The arbiter grants one client at a time and registers that client's digits onto the BCD0..BCD3 inputs of the seven-segment scan decoder. When no client holds the display, it drives a blank pattern.

## Interface
- `MAX_HOLD`, default 1000: clk cycles a granted client keeps the display before yielding to another pending requester; legal range ≥ 2.
- `BLANK_CODE`, default 4'hF: nibble driven for a blank digit. Any value > 9 blanks at the decoder.

Ports (clock and reset first):
- `clk`  input  1: system clock, rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `req`  input  3: request per client; bit i = client i.
- `data0`  input  16: client 0 digits; [3:0] → BCD0 (rightmost) … [15:12] → BCD3.
- `data1`  input  16: client 1 digits, same packing.
- `data2`  input  16: client 2 digits, same packing.
- `gnt`  output  3: one-hot grant, registered.
- `busy`  output  1: high while any grant is active.
- `BCD0`, `BCD1`, `BCD2`, `BCD3`  output  4 each: digits to the decoder, registered.

## Operation
- **Reset values:** `gnt` = 3'b000, `busy` = 0, `BCD0`..`BCD3` = `BLANK_CODE`, state = IDLE, hold counter = 0, round-robin pointer = 0.
- **Two states:** IDLE and GRANT. A round-robin pointer `ptr` holds the highest-priority client index; search order is ptr, ptr+1, ptr+2 (mod 3).
- **IDLE:**
  - If any `req` bit is high, grant the first requester in search order: `gnt` one-hot, `busy` = 1, go to GRANT, hold = 0.
  - Otherwise stay in IDLE with BCD blanked.
- **GRANT, owner k:**
  - Each cycle, BCD0..3 ← data_k nibbles (live tracking).
  - Hold counter increments and saturates at `MAX_HOLD` − 1.
- **GRANT, release:** if `req[k]` = 0 at an edge, then `gnt` ← 0, `busy` ← 0, BCD ← blank, `ptr` ← (k+1) mod 3, go to IDLE. The release takes priority over the preempt rule below.
- **GRANT, preempt:** if hold = `MAX_HOLD` − 1 and another `req` bit is high, switch directly to the next requester after k in round-robin order. `gnt` changes in one edge with no blank gap; BCD takes the new client's data on the same edge; hold ← 0; `ptr` ← k+1.
- **GRANT, keep:** if hold is saturated and no other request is pending, k keeps the display indefinitely.
- **Digit content:** nibbles are passed unmodified, apart from the `LZB_EN` option below; values > 9 reach the decoder and blank there.
- **Mid-operation reset:** `rst` high at any edge forces all reset values on that edge, regardless of state or `req`.
- `gnt` is always one-hot or zero.

## Timing
- Request to grant: `req` high sampled at edge n in IDLE gives `gnt`/`busy` high and BCD = data after edge n. Outputs are valid in cycle n+1.
- Data latency: a change on data_k for the current owner appears on BCD one cycle later.
- Release latency: `req[k]` low sampled at edge n gives `gnt` = 0 and BCD blank after edge n. The earliest next grant is after edge n+1, so there is a minimum one-cycle blank gap.
- Preemption: the owner holds for exactly `MAX_HOLD` cycles counted from the grant edge. The switch occurs at the `MAX_HOLD`-th edge after the grant.
- Simultaneous requests in IDLE are resolved by `ptr` in one cycle.

## Configuration
- **`SEG_ARB_LZB_EN` defined:** leading-zero blanking on registered outputs.
  - BCD3 is replaced with `BLANK_CODE` if it is 0.
  - BCD2 is replaced if it and all higher digits are 0 or blanked.
  - BCD1 is replaced under the same rule.
  - BCD0 is never blanked.
  - Latency is unchanged.
- **Undefined:** digits pass through unmodified, and zeros display as 0.

## Test plan
- **Reset:** assert `rst` 2 cycles with `req` = 3'b111 → `gnt` = 0, `busy` = 0, all BCD = 4'hF. Deassert → `gnt` = 3'b001 one cycle later.
- **Single client:** `req` = 3'b010, data1 = 16'h1234 → `gnt` = 3'b010, BCD3..0 = 1,2,3,4. Change data1 to 16'h5678 → BCD updates after 1 cycle. Drop `req` → blank after 1 cycle.
- **Preemption, `MAX_HOLD` = 4:** client 0 granted, client 2 requesting → `gnt` = 3'b001 for exactly 4 cycles, then 3'b100 with no blank cycle. If client 0 still requests, it regains the grant after a further 4 cycles.
- **Round-robin fairness:** `req` = 3'b111 held → grant sequence 001, 010, 100, 001, each lasting `MAX_HOLD` cycles.
- **Release vs. preempt tie:** at the hold-expiry edge, drop `req[0]` while `req[1]` is high → IDLE for one cycle with blank BCD, then `gnt` = 3'b010.
- **`SEG_ARB_LZB_EN`:** data = 16'h0045 → BCD3..0 = F,F,4,5. Data = 16'h0000 → F,F,F,0. Without the macro → 0,0,4,5.
